// File: rtl/free_list_pkg.sv
// rtl/free_list_pkg.sv - shared sizes, tag types and lane-ordering helpers for the free list
package free_list_pkg;

  localparam int NUM_PHYS_REG = 64;
  localparam int NUM_ARCH_REG = 32;
  localparam int SS_SIZE      = 2;
  localparam int FL_SIZE      = NUM_PHYS_REG - NUM_ARCH_REG;

  localparam int PREG_IDX_W = $clog2(NUM_PHYS_REG);
  localparam int FL_IDX_W   = $clog2(FL_SIZE);
  localparam int FL_CNT_W   = FL_IDX_W + 1;
  localparam int LANE_CNT_W = $clog2(SS_SIZE + 1);

  // PHYS_REG carries the ready bit in its MSB above the register index.
  typedef logic [PREG_IDX_W:0]   PHYS_REG;
  typedef logic [PREG_IDX_W-1:0] preg_idx_t;
  typedef logic [FL_IDX_W-1:0]   FL_IDX_T;
  typedef logic [FL_CNT_W-1:0]   fl_cnt_t;
  typedef logic [LANE_CNT_W-1:0] lane_cnt_t;

  localparam PHYS_REG DUMMY_REG = '1;

  function automatic lane_cnt_t bit_count(input logic [SS_SIZE-1:0] v);
    lane_cnt_t r;
    r = '0;
    for (int j = 0; j < SS_SIZE; j++) begin
      r = r + lane_cnt_t'(v[j]);
    end
    return r;
  endfunction

  // Rank of a lane among the set lanes older than it (lane SS_SIZE-1 is oldest).
  function automatic lane_cnt_t prefix_rank(input logic [SS_SIZE-1:0] v, input int lane);
    lane_cnt_t r;
    r = '0;
    for (int j = SS_SIZE - 1; j > lane; j--) begin
      r = r + lane_cnt_t'(v[j]);
    end
    return r;
  endfunction

endpackage

// File: rtl/free_list_if.sv
// rtl/free_list_if.sv - dispatch/retire bundle between the pipeline and the free list
interface free_list_if;
  import free_list_pkg::*;

  logic                         enable;
  logic                         branch_not_taken;
  logic    [SS_SIZE-1:0]        dispatch_en;
  logic    [SS_SIZE-1:0]        dest_valid;
  logic    [SS_SIZE-1:0]        retire_free_en;
  PHYS_REG [SS_SIZE-1:0]        retire_T_old;
  PHYS_REG [SS_SIZE-1:0]        T_new_out;
  logic    [SS_SIZE-1:0]        T_new_valid;
  logic    [FL_CNT_W-1:0]       free_count;
  logic                         empty;

  modport master (
    output enable, branch_not_taken, dispatch_en, dest_valid, retire_free_en, retire_T_old,
    input  T_new_out, T_new_valid, free_count, empty
  );

  modport slave (
    input  enable, branch_not_taken, dispatch_en, dest_valid, retire_free_en, retire_T_old,
    output T_new_out, T_new_valid, free_count, empty
  );

endinterface

// File: rtl/free_list.sv
// rtl/free_list.sv - circular physical-tag free list with one-cycle flush to committed state
module free_list
  import free_list_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  free_list_if.slave   fl
);

  preg_idx_t entry_q [FL_SIZE];
  FL_IDX_T   head_q, head_d;
  FL_IDX_T   arch_head_q, arch_head_d;
  FL_IDX_T   tail_q, tail_d;
  fl_cnt_t   count_q, count_d;

  logic [SS_SIZE-1:0] req;
  logic [SS_SIZE-1:0] grant;
  logic [SS_SIZE-1:0] push;
  lane_cnt_t          n_grant;
  lane_cnt_t          n_push;
  lane_cnt_t          req_rank  [SS_SIZE];
  FL_IDX_T            alloc_idx [SS_SIZE];
  FL_IDX_T            push_idx  [SS_SIZE];

  logic unused_ready_bits;

  always_comb begin
    unused_ready_bits = 1'b0;
    for (int l = 0; l < SS_SIZE; l++) begin
      unused_ready_bits = unused_ready_bits ^ fl.retire_T_old[l][PREG_IDX_W];
    end
  end

  // Requests are ranked oldest-first; since ranks are dense, k < count keeps grants in order.
  always_comb begin
    req  = {SS_SIZE{fl.enable & ~fl.branch_not_taken & ~reset}} & fl.dispatch_en & fl.dest_valid;
    push = {SS_SIZE{fl.enable}} & fl.retire_free_en;
    grant           = '0;
    fl.T_new_valid  = '0;
    fl.T_new_out    = {SS_SIZE{DUMMY_REG}};
    for (int l = 0; l < SS_SIZE; l++) begin
      req_rank[l]  = prefix_rank(req, l);
      alloc_idx[l] = head_q + FL_IDX_T'(req_rank[l]);
      push_idx[l]  = tail_q + FL_IDX_T'(prefix_rank(push, l));
      grant[l]     = req[l] && (fl_cnt_t'(req_rank[l]) < count_q);
      if (grant[l]) begin
        fl.T_new_valid[l] = 1'b1;
        fl.T_new_out[l]   = {1'b0, entry_q[alloc_idx[l]]};
      end
    end
    n_grant = bit_count(grant);
    n_push  = bit_count(push);
  end

  // A flush rewinds head to the committed head; same-cycle retires still advance it.
  always_comb begin
    tail_d      = tail_q + FL_IDX_T'(n_push);
    arch_head_d = arch_head_q + FL_IDX_T'(n_push);
    if (fl.branch_not_taken) begin
      head_d  = arch_head_d;
      count_d = fl_cnt_t'(FL_SIZE);
    end else begin
      head_d  = head_q + FL_IDX_T'(n_grant);
      count_d = count_q - fl_cnt_t'(n_grant) + fl_cnt_t'(n_push);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FL_SIZE; i++) begin
        entry_q[i] <= preg_idx_t'(NUM_ARCH_REG + i);
      end
      head_q      <= '0;
      arch_head_q <= '0;
      tail_q      <= '0;
      count_q     <= fl_cnt_t'(FL_SIZE);
    end else begin
      for (int l = 0; l < SS_SIZE; l++) begin
        if (push[l]) begin
          entry_q[push_idx[l]] <= fl.retire_T_old[l][PREG_IDX_W-1:0];
        end
      end
      head_q      <= head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !fl.branch_not_taken) begin
      assert (int'(count_q) + int'(n_push) - int'(n_grant) <= FL_SIZE);
    end
  end

  assign fl.free_count = count_q;
  assign fl.empty      = (count_q == '0);

endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - randomized and directed checks of free_list against a queue model
module tb_free_list;
  import free_list_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;

  free_list_if fl_if ();

  free_list dut (
    .clock (clock),
    .reset (reset),
    .fl    (fl_if)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  int spec_q[$];
  int arch_q[$];
  int inflight = 0;

  logic [SS_SIZE-1:0] obs_v;
  PHYS_REG            obs_tag [SS_SIZE];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    fl_if.enable           = 1'b1;
    fl_if.branch_not_taken = 1'b0;
    fl_if.dispatch_en      = '0;
    fl_if.dest_valid       = '0;
    fl_if.retire_free_en   = '0;
    fl_if.retire_T_old     = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    drive_idle();
    fl_if.dispatch_en = '1;
    fl_if.dest_valid  = '1;
    @(posedge clock);
    #1;
    check("reset_valid", fl_if.T_new_valid, 0);
    check("reset_tag1", fl_if.T_new_out[1], DUMMY_REG);
    @(negedge clock);
    reset = 1'b0;
    drive_idle();
    #1;
    check("reset_count", fl_if.free_count, 32);
    check("reset_empty", fl_if.empty, 0);
    spec_q.delete();
    arch_q.delete();
    for (int i = 0; i < FL_SIZE; i++) begin
      spec_q.push_back(NUM_ARCH_REG + i);
      arch_q.push_back(NUM_ARCH_REG + i);
    end
    inflight = 0;
  endtask

  task automatic step(input logic en, input logic bnt, input logic [1:0] disp,
                      input logic [1:0] dv, input logic [1:0] rfe,
                      input PHYS_REG t1, input PHYS_REG t0);
    logic [1:0] exp_v;
    PHYS_REG    exp_tag [SS_SIZE];
    PHYS_REG    told    [SS_SIZE];
    int         k;
    int         avail;
    told[1] = t1;
    told[0] = t0;
    @(negedge clock);
    check("free_count", fl_if.free_count, spec_q.size());
    check("empty", fl_if.empty, (spec_q.size() == 0) ? 1 : 0);
    fl_if.enable           = en;
    fl_if.branch_not_taken = bnt;
    fl_if.dispatch_en      = disp;
    fl_if.dest_valid       = dv;
    fl_if.retire_free_en   = rfe;
    fl_if.retire_T_old[1]  = t1;
    fl_if.retire_T_old[0]  = t0;
    #1;
    avail = spec_q.size();
    k = 0;
    for (int l = SS_SIZE - 1; l >= 0; l--) begin
      exp_v[l]   = 1'b0;
      exp_tag[l] = DUMMY_REG;
      if (en && !bnt && disp[l] && dv[l]) begin
        if (k < avail) begin
          exp_v[l]   = 1'b1;
          exp_tag[l] = PHYS_REG'(spec_q[k]);
        end
        k++;
      end
    end
    for (int l = 0; l < SS_SIZE; l++) begin
      obs_v[l]   = fl_if.T_new_valid[l];
      obs_tag[l] = fl_if.T_new_out[l];
      check($sformatf("valid%0d", l), obs_v[l], exp_v[l]);
      check($sformatf("tag%0d", l), obs_tag[l], exp_tag[l]);
    end
    @(posedge clock);
    for (int l = SS_SIZE - 1; l >= 0; l--) begin
      if (exp_v[l]) begin
        void'(spec_q.pop_front());
        inflight++;
      end
    end
    for (int l = SS_SIZE - 1; l >= 0; l--) begin
      if (en && rfe[l]) begin
        spec_q.push_back(int'(told[l][PREG_IDX_W-1:0]));
        arch_q.push_back(int'(told[l][PREG_IDX_W-1:0]));
        void'(arch_q.pop_front());
        inflight--;
      end
    end
    if (bnt) begin
      spec_q   = arch_q;
      inflight = 0;
    end
  endtask

  initial begin
    logic       en, bnt;
    logic [1:0] disp, dv, rfe;
    int         n;

    drive_idle();
    do_reset();

    step(1, 0, 2'b11, 2'b11, 2'b00, 0, 0);
    check("first_tag_lane1", obs_tag[1], 32);
    check("first_tag_lane0", obs_tag[0], 33);
    #1;
    check("count_after_first", fl_if.free_count, 30);

    for (int i = 0; i < 14; i++) step(1, 0, 2'b11, 2'b11, 2'b00, 0, 0);
    step(1, 0, 2'b10, 2'b10, 2'b00, 0, 0);
    step(1, 0, 2'b11, 2'b11, 2'b00, 0, 0);
    check("last_tag_lane1", obs_tag[1], 63);
    check("last_valid_lane0", obs_v[0], 0);
    step(1, 0, 2'b11, 2'b11, 2'b00, 0, 0);
    check("empty_no_grant", obs_v, 0);

    step(1, 0, 2'b00, 2'b00, 2'b11, 7'd5, 7'd7);
    step(1, 0, 2'b11, 2'b11, 2'b00, 0, 0);
    check("wrap_tag_lane1", obs_tag[1], 5);
    check("wrap_tag_lane0", obs_tag[0], 7);

    step(1, 0, 2'b10, 2'b10, 2'b10, 7'd9, 0);
    check("no_bypass", obs_v, 0);
    step(1, 0, 2'b10, 2'b10, 2'b00, 0, 0);
    check("bypass_next_tag", obs_tag[1], 9);

    do_reset();
    step(1, 0, 2'b11, 2'b11, 2'b00, 0, 0);
    step(1, 0, 2'b11, 2'b11, 2'b00, 0, 0);
    step(1, 0, 2'b00, 2'b00, 2'b10, 7'd3, 0);
    step(1, 1, 2'b11, 2'b11, 2'b10, 7'd4, 0);
    check("flush_no_grant", obs_v, 0);
    #1;
    check("flush_count", fl_if.free_count, 32);
    step(1, 0, 2'b11, 2'b11, 2'b00, 0, 0);
    check("flush_tag_lane1", obs_tag[1], 34);
    check("flush_tag_lane0", obs_tag[0], 35);
    step(1, 0, 2'b11, 2'b01, 2'b00, 0, 0);
    check("dv_lane1_off", obs_v[1], 0);
    check("dv_lane0_tag", obs_tag[0], 36);
    step(0, 0, 2'b11, 2'b11, 2'b11, 7'd1, 7'd2);
    check("disabled_valid", obs_v, 0);
    #1;
    check("disabled_count", fl_if.free_count, 29);

    for (int c = 0; c < 800; c++) begin
      en   = ($urandom_range(0, 9) != 0);
      bnt  = ($urandom_range(0, 29) == 0);
      disp = 2'($urandom_range(0, 3));
      dv   = (c < 400) ? 2'b11 : 2'($urandom_range(0, 3));
      n    = (inflight < 2) ? inflight : 2;
      n    = $urandom_range(0, n);
      if (c < 400 && $urandom_range(0, 3) != 0) n = 0;
      case (n)
        0:       rfe = 2'b00;
        1:       rfe = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
        default: rfe = 2'b11;
      endcase
      step(en, bnt, disp, dv, rfe, PHYS_REG'($urandom), PHYS_REG'($urandom));
    end
    step(1, 0, 2'b00, 2'b00, 2'b00, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Circular free list of physical register tags; sits directly upstream of the ROB and map table in dispatch.
- Supplies up to SS_SIZE fresh T_new tags per cycle to dispatch.
- Accepts up to SS_SIZE T_old tags per cycle back from retire.
- Keeps an architectural head pointer so that a full pipeline flush (branch_not_taken) restores the list to its committed state in one cycle.

Parameters:
- NUM_PHYS_REG, 64, total physical registers (`NUM_PHYS_REG).
- NUM_ARCH_REG, 32, architectural registers; tags 0..NUM_ARCH_REG-1 are the reset architectural mapping.
- SS_SIZE, 2, superscalar width (`SS_SIZE).
- FL_SIZE, NUM_PHYS_REG-NUM_ARCH_REG (32), list capacity; a power of two.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  global stage enable; when 0, no pop and no push is performed
- branch_not_taken  in  1  mispredict flush, same signal the ROB flushes on
- dispatch_en  in  [SS_SIZE]  lane is dispatching this cycle
- dest_valid  in  [SS_SIZE]  dispatching lane writes a register (wr_idx != ZERO_REG)
- retire_free_en  in  [SS_SIZE]  retiring lane allocated a register (its T_new != DUMMY_REG)
- retire_T_old  in  PHYS_REG [SS_SIZE]  T_old of the retiring lane, pushed back to the list
- T_new_out  out  PHYS_REG [SS_SIZE]  allocated tag per lane, ready bit (MSB) = 0
- T_new_valid  out  [SS_SIZE]  lane was granted a tag this cycle
- free_count  out  [$clog2(FL_SIZE):0]  registered number of free entries
- empty  out  1  free_count == 0

Behaviour:
- Lane order: lane SS_SIZE-1 is oldest, matching ROB dispatch and retire ordering. Requests and pushes are considered from lane SS_SIZE-1 down to lane 0.
- State: entry array [FL_SIZE] of tag index, head, arch_head, tail (each $clog2(FL_SIZE) bits, wrap modulo FL_SIZE), and count.
- Reset:
  - entry[i] = NUM_ARCH_REG+i.
  - head = arch_head = tail = 0.
  - count = FL_SIZE.
  - All outputs: T_new_valid = 0, T_new_out = DUMMY_REG, free_count = FL_SIZE, empty = 0 (reflects registered count).
- Allocation (combinational, same cycle):
  - Requesting lanes are those with enable & dispatch_en & dest_valid & !branch_not_taken.
  - The k-th requesting lane (k = 0 for the oldest) is granted entry[head+k] only if k < count.
  - Grants are strictly in order: once a request is denied, all younger lanes are denied.
  - Non-requesting lanes output T_new_valid = 0 and T_new_out = DUMMY_REG.
  - head_next = head + number of grants.
- No bypass: tags pushed this cycle are never allocatable before the next cycle. Allocation sees only the registered count.
- Free (retire):
  - Each lane with enable & retire_free_en writes retire_T_old (index bits only) to entry[tail+j], where j is its rank among such lanes, oldest first.
  - tail_next = tail + pushes.
  - arch_head_next = arch_head + pushes. Each retired allocation consumes exactly one committed entry.
  - Pushes are accepted during a flush; retire is already gated upstream.
- count_next = count - grants + pushes. The architectural count is invariantly FL_SIZE, so no arch_count register is needed.
- Flush (branch_not_taken at posedge):
  - head <= arch_head_next and count <= FL_SIZE.
  - Pushes of the same cycle still apply (tail and arch_head advance).
  - No grants are issued in the flush cycle.
- Overflow: if count + pushes - grants would exceed FL_SIZE, this is an illegal-input condition. Assert in simulation; the RTL takes no corrective action.
- enable = 0: the state holds and all T_new_valid = 0. A flush still applies.
- Widths: count uses $clog2(FL_SIZE)+1 bits. Pointer arithmetic truncates to $clog2(FL_SIZE) bits, giving natural wrap.
- Output tag: {1'b0, entry index bits} zero-extended to PHYS_REG.

Decomposition:
- In sys_defs.vh / shared package:
  - FL_SIZE macro.
  - FL_IDX_T typedef ($clog2(FL_SIZE) bits).
  - Reuse of the existing PHYS_REG, DUMMY_REG and BIT_COUNT_LUT for grant/push counts.
- No sub-module is needed. An optional in-order prefix-rank function belongs in the package, since the ROB can share it.

Test Plan:
- Reset, then check state -> free_count = 32, empty = 0. Then 2 lanes dispatch with dest_valid=11 -> lane1 gets tag 32, lane0 gets tag 33, free_count = 30 next cycle.
- Drain to count = 1, then request both lanes -> only lane1 is granted (tag 63); lane0 T_new_valid = 0 with DUMMY_REG. Next cycle empty = 1, and any requests get no grants.
- Wrap: allocate 32 tags, retire-free tags 5 and 7, allocate 2 -> grants are 5 then 7 from entry[0..1] after tail wrap; count returns to 0.
- Same cycle, count = 0: retire pushes tag 9 and dispatch requests one lane -> no grant this cycle; next cycle count = 1, and the request is then granted tag 9.
- Allocate 4 (32..35), retire 1 with T_old = 3, then assert branch_not_taken in the same cycle as a second retire with T_old = 4 -> next cycle count = 32. The next allocations yield 34, 35, … with tags 3 and 4 at the tail (committed-list order).
- dest_valid = 0 on lane1 with lane0 requesting -> lane0 gets the head tag and lane1 T_new_valid = 0. With enable = 0, no state changes occur.
